// File: rtl/pipe_issue.sv
// In-order instruction issue stage: FIFO buffer, decode, optional RAW interlock.
// Define ISSUE_HAZARD_EN to build the destination scoreboard and stall logic.
module pipe_issue #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned HAZ_DIST = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [23:0]              in_instr,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [3:0]               rs1,
  output logic [3:0]               rs2,
  output logic [3:0]               rd,
  output logic [3:0]               func,
  output logic [7:0]               addr,
  output logic                     out_valid,
  output logic                     illegal,
  output logic [$clog2(DEPTH):0]   fill,
  output logic [15:0]              issue_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || HAZ_DIST < 1) begin : g_param_check
    $error("pipe_issue: DEPTH must be a power of two >= 2 and HAZ_DIST >= 1");
  end

  logic [23:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   fill_q, fill_d;

  logic [23:0] head;
  logic [3:0]  head_func, head_rd, head_rs1, head_rs2;
  logic [7:0]  head_addr;
  logic        not_empty, head_illegal, hazard;
  logic        push, issue, drop, pop;

  assign head      = mem[rd_ptr_q];
  assign head_func = head[23:20];
  assign head_rd   = head[19:16];
  assign head_rs1  = head[15:12];
  assign head_rs2  = head[11:8];
  assign head_addr = head[7:0];

  assign not_empty    = (fill_q != '0);
  assign head_illegal = (head_func[3:2] == 2'b11);
  assign in_ready     = (fill_q != FULL_LVL);
  assign fill         = fill_q;

  // Flush wins over every other action in the same cycle.
  assign push  = in_valid && in_ready && !flush;
  assign issue = not_empty && !head_illegal && !hazard && !flush;
  assign drop  = not_empty && head_illegal && !flush;
  assign pop   = issue || drop;

  always_comb begin
    fill_d = fill_q;
    if (flush) begin
      fill_d = '0;
    end else begin
      unique case ({push, pop})
        2'b10:   fill_d = fill_q + 1'b1;
        2'b01:   fill_d = fill_q - 1'b1;
        default: fill_d = fill_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= in_instr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      fill_q    <= '0;
      out_valid <= 1'b0;
      illegal   <= 1'b0;
      issue_cnt <= '0;
      rs1       <= '0;
      rs2       <= '0;
      rd        <= '0;
      func      <= '0;
      addr      <= '0;
    end else begin
      fill_q    <= fill_d;
      out_valid <= issue;
      illegal   <= drop;
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (issue) begin
        rs1       <= head_rs1;
        rs2       <= head_rs2;
        rd        <= head_rd;
        func      <= head_func;
        addr      <= head_addr;
        issue_cnt <= issue_cnt + 16'd1;
      end
    end
  end

`ifdef ISSUE_HAZARD_EN
  logic [HAZ_DIST-1:0]      sb_vld_q, sb_vld_d;
  logic [HAZ_DIST-1:0][3:0] sb_rd_q, sb_rd_d;
  logic                     use_rs1, use_rs2;

  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (head_func)
      4'd0, 4'd1, 4'd2, 4'd5, 4'd6, 4'd7: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      4'd3, 4'd8, 4'd10, 4'd11: use_rs1 = 1'b1;
      4'd4, 4'd9:               use_rs2 = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < HAZ_DIST; i++) begin
      if (sb_vld_q[i] && ((use_rs1 && sb_rd_q[i] == head_rs1) ||
                          (use_rs2 && sb_rd_q[i] == head_rs2))) begin
        hazard = 1'b1;
      end
    end
  end

  // Slot 0 records this cycle's issue; older slots age toward retirement.
  always_comb begin
    sb_vld_d    = '0;
    sb_rd_d     = '0;
    sb_vld_d[0] = issue;
    sb_rd_d[0]  = issue ? head_rd : 4'd0;
    for (int i = 1; i < HAZ_DIST; i++) begin
      sb_vld_d[i] = sb_vld_q[i-1];
      sb_rd_d[i]  = sb_rd_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_vld_q <= '0;
      sb_rd_q  <= '0;
    end else if (flush) begin
      sb_vld_q <= '0;
      sb_rd_q  <= '0;
    end else begin
      sb_vld_q <= sb_vld_d;
      sb_rd_q  <= sb_rd_d;
    end
  end
`else
  assign hazard = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_issue.sv
// Directed bench for pipe_issue; hazard scenarios compile in with ISSUE_HAZARD_EN.
module tb_pipe_issue;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready;
  logic [23:0] in_instr;
  logic [3:0]  rs1, rs2, rd, func;
  logic [7:0]  addr;
  logic        out_valid, illegal;
  logic [3:0]  fill;
  logic [15:0] issue_cnt;

  int checks = 0;
  int errors = 0;

  pipe_issue #(.DEPTH(8), .HAZ_DIST(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_instr  (in_instr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rs1       (rs1),
    .rs2       (rs2),
    .rd        (rd),
    .func      (func),
    .addr      (addr),
    .out_valid (out_valid),
    .illegal   (illegal),
    .fill      (fill),
    .issue_cnt (issue_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] mk(input logic [3:0] f, input logic [3:0] d,
                                     input logic [3:0] s1, input logic [3:0] s2,
                                     input logic [7:0] a);
    return {f, d, s1, s2, a};
  endfunction

  task automatic push1(input logic [23:0] w);
    in_instr = w;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0;
    tick();
    tick();
    check("rst_fill", 32'(fill), 0);
    check("rst_ov", 32'(out_valid), 0);
    check("rst_ill", 32'(illegal), 0);
    check("rst_cnt", 32'(issue_cnt), 0);
    check("rst_flds", {rs1, rs2, rd, func, addr}, 0);
    check("rst_ready", 32'(in_ready), 1);
    in_instr = mk(4'd0, 4'd1, 4'd2, 4'd3, 8'h55);
    in_valid = 1'b1;
    tick();
    check("rst_nopush", 32'(fill), 0);
    rst = 1'b0;
    in_valid = 1'b0;
    tick();

    // Basic issue: one cycle of latency from FIFO write to outputs.
    push1(mk(4'd0, 4'd1, 4'd2, 4'd3, 8'h10));
    check("b_fill1", 32'(fill), 1);
    check("b_ov0", 32'(out_valid), 0);
    tick();
    check("b_ov1", 32'(out_valid), 1);
    check("b_flds", {rs1, rs2, rd, func, addr}, {4'd2, 4'd3, 4'd1, 4'd0, 8'h10});
    check("b_cnt", 32'(issue_cnt), 1);
    check("b_fill0", 32'(fill), 0);
    tick();
    check("b_ov_low", 32'(out_valid), 0);
    check("b_hold", {rs1, rs2, rd, func, addr}, {4'd2, 4'd3, 4'd1, 4'd0, 8'h10});

    // func 4 reads rs2 only, so rs1 matching the producer's rd must not stall.
    push1(mk(4'd0, 4'd5, 4'd1, 4'd2, 8'h20));
    in_instr = mk(4'd4, 4'd7, 4'd5, 4'd6, 8'h21);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("ns_ov_a", 32'(out_valid), 1);
    check("ns_rd_a", 32'(rd), 5);
    tick();
    check("ns_ov_b", 32'(out_valid), 1);
    check("ns_flds_b", {rs1, rs2, rd, func, addr}, {4'd5, 4'd6, 4'd7, 4'd4, 8'h21});
    check("ns_cnt", 32'(issue_cnt), 3);
    tick();

    // Illegal func is dropped with a one-cycle pulse; outputs keep last issue.
    push1(mk(4'd13, 4'd2, 4'd3, 4'd4, 8'h33));
    check("il_fill1", 32'(fill), 1);
    check("il_pre", 32'(illegal), 0);
    tick();
    check("il_pulse", 32'(illegal), 1);
    check("il_ov", 32'(out_valid), 0);
    check("il_fill0", 32'(fill), 0);
    check("il_hold", {rd, func, addr}, {4'd7, 4'd4, 8'h21});
    check("il_cnt", 32'(issue_cnt), 3);
    tick();
    check("il_end", 32'(illegal), 0);

    // Illegal followed back-to-back by a legal word.
    push1(mk(4'd15, 4'd1, 4'd1, 4'd1, 8'h40));
    in_instr = mk(4'd1, 4'd9, 4'd3, 4'd4, 8'h41);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("il2_pulse", 32'(illegal), 1);
    check("il2_ov", 32'(out_valid), 0);
    check("il2_fill", 32'(fill), 1);
    tick();
    check("il2_ov1", 32'(out_valid), 1);
    check("il2_flds", {rd, func, addr}, {4'd9, 4'd1, 8'h41});
    check("il2_ill0", 32'(illegal), 0);
    check("il2_cnt", 32'(issue_cnt), 4);
    tick();

    // Flush beats a same-cycle push, then beats a pending issue.
    in_instr = mk(4'd0, 4'd3, 4'd3, 4'd3, 8'h50);
    in_valid = 1'b1;
    flush = 1'b1;
    tick();
    check("fl_push_fill", 32'(fill), 0);
    check("fl_push_ov", 32'(out_valid), 0);
    flush = 1'b0;
    push1(mk(4'd0, 4'd3, 4'd3, 4'd3, 8'h51));
    check("fl_fill1", 32'(fill), 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_fill0", 32'(fill), 0);
    check("fl_ov", 32'(out_valid), 0);
    check("fl_cnt", 32'(issue_cnt), 4);
    tick();
    check("fl_ov_after", 32'(out_valid), 0);

`ifdef ISSUE_HAZARD_EN
    begin
      int n;
      bit seen;
      // Dependent word behind its producer issues three edges later.
      push1(mk(4'd0, 4'd5, 4'd1, 4'd2, 8'h60));
      in_instr = mk(4'd0, 4'd6, 4'd5, 4'd2, 8'h61);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check("hz_prod", 32'(out_valid), 1);
      tick();
      check("hz_bub1", 32'(out_valid), 0);
      tick();
      check("hz_bub2", 32'(out_valid), 0);
      tick();
      check("hz_dep", 32'(out_valid), 1);
      check("hz_dep_rd", 32'(rd), 6);
      tick();

      // Self-dependent chain drains at one per three cycles, so the FIFO fills.
      in_instr = mk(4'd0, 4'd5, 4'd5, 4'd5, 8'h70);
      in_valid = 1'b1;
      n = 0;
      while (in_ready && n < 40) begin
        tick();
        n++;
      end
      check("full_bound", 32'(in_ready), 0);
      check("full_fill", 32'(fill), 8);
      tick();
      check("full_reject", 32'(fill), out_valid ? 32'd7 : 32'd8);
      in_valid = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 6 && !seen; i++) begin
        tick();
        seen = out_valid;
      end
      check("hz_wait_issue", 32'(seen), 1);
      check("fl_hz_fill", 32'(fill) >= 4 ? 32'd1 : 32'd0, 1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("fl_hz_fill0", 32'(fill), 0);
      check("fl_hz_ov", 32'(out_valid), 0);
      push1(mk(4'd0, 4'd8, 4'd5, 4'd5, 8'h71));
      tick();
      check("fl_hz_nostall", 32'(out_valid), 1);
      check("fl_hz_rd", 32'(rd), 8);
      tick();
    end
`endif

    // Asynchronous reset mid-operation discards buffered words.
    push1(mk(4'd2, 4'd4, 4'd1, 4'd1, 8'h80));
    check("mr_fill1", 32'(fill), 1);
    #2;
    rst = 1'b1;
    #1;
    check("mr_fill0", 32'(fill), 0);
    check("mr_ready", 32'(in_ready), 1);
    check("mr_cnt", 32'(issue_cnt), 0);
    check("mr_flds", {rs1, rs2, rd, func, addr}, 0);
    tick();
    rst = 1'b0;
    tick();
    check("mr_noissue", 32'(out_valid), 0);
    check("mr_cnt_after", 32'(issue_cnt), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
